// File: rtl/seq_mag_cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encoding and the WIDTH/CHUNK legality check used at elaboration time.
package seq_mag_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when the operand width splits into whole chunks of a legal size.
    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/seq_mag_cmp_chunk.sv
// Combinational CHUNK-bit unsigned magnitude comparator (XNOR-prefix form).
module mag_cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    logic [CHUNK-1:0] w_e;
    logic             w_hi_eq;

    assign w_e = x ~^ y;
    assign eq  = &w_e;

    // Walk MSB->LSB: a bit decides the result only if every higher bit matched.
    always_comb begin
        gt      = 1'b0;
        lt      = 1'b0;
        w_hi_eq = 1'b1;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            gt      = gt | (w_hi_eq & x[i] & ~y[i]);
            lt      = lt | (w_hi_eq & ~x[i] & y[i]);
            w_hi_eq = w_hi_eq & w_e[i];
        end
    end

endmodule

// File: rtl/seq_mag_cmp.sv
// Multi-cycle magnitude comparator: scans latched operands MSB-first one
// chunk per cycle and stops at the first differing chunk. Signed compares
// are turned into unsigned ones by flipping both sign bits on accept.
module seq_mag_cmp
    import seq_mag_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int CW = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             agtb,
    output logic             altb,
    output logic             aeqb,
    output logic [CW-1:0]    cycles
);

    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
            $error("seq_mag_cmp: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cycles;
    logic             r_agtb;
    logic             r_altb;
    logic             r_aeqb;

    logic [CHUNK-1:0] w_xs;
    logic [CHUNK-1:0] w_ys;
    logic             w_gt;
    logic             w_lt;
    logic             w_eq;
    logic             w_accept;
    logic             w_last;

    assign w_xs     = r_a[r_idx*CHUNK +: CHUNK];
    assign w_ys     = r_b[r_idx*CHUNK +: CHUNK];
    assign w_accept = start_valid && (r_state == ST_IDLE);
    assign w_last   = (r_idx == '0);

    mag_cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x  (w_xs),
        .y  (w_ys),
        .gt (w_gt),
        .lt (w_lt),
        .eq (w_eq)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: stop scanning at the first mismatch or after chunk 0.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start_valid)        w_state_nxt = ST_CMP;
            ST_CMP:  if (!w_eq || w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (res_ready)          w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch, chunk walk and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_cycles <= '0;
            r_agtb   <= 1'b0;
            r_altb   <= 1'b0;
            r_aeqb   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a ^ (signed_mode ? MSB_MASK : '0);
            r_b      <= b ^ (signed_mode ? MSB_MASK : '0);
            r_idx    <= IW'(NCHUNK - 1);
            r_cycles <= '0;
        end else if (r_state == ST_CMP) begin
            r_cycles <= r_cycles + CW'(1);
            if (!w_eq) begin
                r_agtb <= w_gt;
                r_altb <= w_lt;
                r_aeqb <= 1'b0;
            end else if (w_last) begin
                r_agtb <= 1'b0;
                r_altb <= 1'b0;
                r_aeqb <= 1'b1;
            end else begin
                r_idx  <= r_idx - IW'(1);
            end
        end
    end

    assign start_ready = (r_state == ST_IDLE);
    assign res_valid   = (r_state == ST_DONE);
    assign agtb        = r_agtb;
    assign altb        = r_altb;
    assign aeqb        = r_aeqb;
    assign cycles      = r_cycles;

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Scoreboard bench for seq_mag_cmp (WIDTH=32, CHUNK=4): directed cases from
// the test plan followed by randomized traffic with random backpressure.
module tb_seq_mag_cmp;

    localparam int W  = 32;
    localparam int C  = 4;
    localparam int NC = W / C;
    localparam int CWB = $clog2(NC + 1);

    typedef struct {
        logic gt;
        logic lt;
        logic eq;
        int   cyc;
        int   acc;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           start_valid;
    logic           start_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           signed_mode;
    logic           res_valid;
    logic           res_ready;
    logic           agtb;
    logic           altb;
    logic           aeqb;
    logic [CWB-1:0] cycles;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    logic rr_force = 1'b1;
    logic rr_val   = 1'b1;

    seq_mag_cmp #(.WIDTH(W), .CHUNK(C)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .agtb        (agtb),
        .altb        (altb),
        .aeqb        (aeqb),
        .cycles      (cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain integer comparison; chunks examined = chunks from the
    // top down to (and including) the one holding the highest differing bit.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s);
        exp_t e;
        logic [W-1:0] d;
        int p;
        if (s) begin
            e.gt = $signed(x) > $signed(y);
            e.lt = $signed(x) < $signed(y);
        end else begin
            e.gt = x > y;
            e.lt = x < y;
        end
        e.eq = (x == y);
        d = x ^ y;
        p = -1;
        for (int i = 0; i < W; i++) if (d[i]) p = i;
        e.cyc = (p < 0) ? NC : NC - p / C;
        e.acc = 0;
        return e;
    endfunction

    // Consumer ready: either forced by the directed sections or random.
    initial begin
        forever begin
            @(negedge clk);
            res_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: while a result is shown it must match the scoreboard head;
    // the head is retired when the consumer takes it.
    initial begin
        logic prev_rv;
        exp_t e;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rv = 1'b0;
            end else begin
                if (res_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: res_valid=1, want no result pending (t=%0t)", $time);
                    end else begin
                        e = exp_q[0];
                        if (!prev_rv) chk("latency", cyc - e.acc, e.cyc);
                        chk("agtb", agtb, e.gt);
                        chk("altb", altb, e.lt);
                        chk("aeqb", aeqb, e.eq);
                        chk("cycles", cycles, e.cyc);
                        if (res_ready) void'(exp_q.pop_front());
                    end
                end
                prev_rv = res_valid;
            end
        end
    end

    task automatic do_req(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (!start_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            total++;
            bad++;
            $display("FAIL start_ready_timeout: start_ready=0, want 1");
            return;
        end
        a = x;
        b = y;
        signed_mode = s;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        e = model(x, y, s);
        e.acc = cyc;
        exp_q.push_back(e);
        start_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        signed_mode = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !start_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", (exp_q.size() == 0) && start_ready, 1);
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        int n;
        rst_n = 1'b1;
        start_valid = 1'b0;
        a = '0;
        b = '0;
        signed_mode = 1'b0;
        #2 rst_n = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_flags", {agtb, altb, aeqb}, 0);
        chk("rst_cycles", cycles, 0);
        rst_n = 1'b1;

        // Directed test-plan cases, consumer always ready.
        do_req(32'h12345678, 32'h12345678, 1'b0);
        wait_idle();
        do_req(32'h90000000, 32'h80000000, 1'b0);
        wait_idle();
        do_req(32'h12345670, 32'h12345671, 1'b0);
        wait_idle();
        do_req(32'hFFFFFFFF, 32'h00000001, 1'b1);
        wait_idle();
        do_req(32'hFFFFFFFF, 32'h00000001, 1'b0);
        wait_idle();

        // Backpressure: hold the result, pulse a request that must be ignored.
        rr_val = 1'b0;
        do_req(32'h00000010, 32'h00000020, 1'b0);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_res_valid_seen", res_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_start_ready", start_ready, 0);
            chk("bp_res_valid", res_valid, 1);
            if (k == 1) begin
                a = 32'hDEADBEEF;
                b = 32'h00000000;
                start_valid = 1'b1;
            end else begin
                start_valid = 1'b0;
            end
        end
        rr_val = 1'b1;
        n = 0;
        while (res_valid && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("bp_release_res_valid", res_valid, 0);
        chk("bp_release_start_ready", start_ready, 1);
        do_req(32'h00000003, 32'h00000002, 1'b0);
        wait_idle();

        // Reset during the third CMP cycle of an equal compare.
        do_req(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_flags", {agtb, altb, aeqb}, 0);
        chk("mid_rst_cycles", cycles, 0);
        chk("mid_rst_start_ready", start_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_req(32'd5, 32'd7, 1'b0);
        wait_idle();

        // Randomized traffic with random consumer backpressure.
        rr_force = 1'b0;
        for (int t = 0; t < 60; t++) begin
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = x;
                1: y = x ^ (W'(1) << $urandom_range(0, W - 1));
                2: y = {x[W-1:16], 16'($urandom)};
                default: y = $urandom;
            endcase
            do_req(x, y, 1'($urandom_range(0, 1)));
        end
        wait_idle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1, "timeout");
    end

endmodule
